// File: rtl/divider_if.sv
// divider_if: start/busy/done handshake and operand/result bus between issue logic and the divider
interface divider_if #(parameter int WIDTH = 32);
  logic             start;
  logic             isSigned;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             divByZero;
  logic             overflow;
  modport master (output start, isSigned, dividend, divisor,
                  input busy, done, quotient, remainder, divByZero, overflow);
  modport slave (input start, isSigned, dividend, divisor,
                 output busy, done, quotient, remainder, divByZero, overflow);
endinterface

// File: rtl/divider.sv
// divider: iterative radix-2 restoring divider, signed/unsigned, RISC-V M-extension corner cases
module divider #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst_n,
  divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_q, r_d, r_quot, r_remo;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q, r_neg_r, r_dz, r_ov;
  logic [1:0]       r_fast;
  logic             w_acc, w_zero, w_ovf, w_last, w_ge;
  logic [WIDTH-1:0] w_min, w_abs_a, w_abs_b, w_q_n;
  logic [WIDTH+1:0] w_sh, w_trial;
  logic [WIDTH:0]   w_rem_n;
  assign w_min   = {1'b1, {(WIDTH-1){1'b0}}};
  assign w_acc   = (r_state == IDLE) && bus.start;
  assign w_zero  = bus.divisor == '0;
  assign w_ovf   = bus.isSigned && (bus.dividend == w_min) && (&bus.divisor);
  assign w_abs_a = (bus.isSigned && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
  assign w_abs_b = (bus.isSigned && bus.divisor[WIDTH-1]) ? -bus.divisor : bus.divisor;
  assign w_last  = r_cnt == CW'(WIDTH - 1);
  // shifted partial remainder minus divisor; the top bit is the borrow since both operands fit
  assign w_sh    = {r_rem, r_q[WIDTH-1]};
  assign w_trial = w_sh - {2'b00, r_d};
  assign w_ge    = ~w_trial[WIDTH+1];
  assign w_rem_n = w_ge ? w_trial[WIDTH:0] : w_sh[WIDTH:0];
  assign w_q_n   = {r_q[WIDTH-2:0], w_ge};
  assign bus.busy      = r_state != IDLE;
  assign bus.done      = r_state == DONE;
  assign bus.quotient  = r_quot;
  assign bus.remainder = r_remo;
  assign bus.divByZero = r_dz;
  assign bus.overflow  = r_ov;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // next state: fast-path ops spend a single RUN cycle, normal ops run WIDTH iterations
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.start ? RUN : IDLE;
      RUN:     w_next = ((|r_fast) || w_last) ? DONE : RUN;
      default: w_next = IDLE;
    endcase
  end
  // operand latch, shift-subtract iteration and result registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rem   <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_ov    <= 1'b0;
      r_fast  <= 2'b00;
    end else if (w_acc) begin
      r_dz    <= 1'b0;
      r_ov    <= 1'b0;
      r_fast  <= {w_ovf, w_zero};
      r_neg_q <= bus.isSigned && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
      r_neg_r <= bus.isSigned && bus.dividend[WIDTH-1];
      r_q     <= (w_zero || w_ovf) ? bus.dividend : w_abs_a;
      r_d     <= w_abs_b;
      r_rem   <= '0;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      if (|r_fast) begin
        r_quot <= r_fast[0] ? '1 : r_q;
        r_remo <= r_fast[0] ? r_q : '0;
        r_dz   <= r_fast[0];
        r_ov   <= r_fast[1];
      end else begin
        r_rem <= w_rem_n;
        r_q   <= w_q_n;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_quot <= r_neg_q ? -w_q_n : w_q_n;
          r_remo <= r_neg_r ? -w_rem_n[WIDTH-1:0] : w_rem_n[WIDTH-1:0];
        end
      end
    end
endmodule

// File: tb/tb_divider.sv
// tb_divider: directed vector table plus busy-start and mid-run reset sequences for divider
module tb_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  divider_if #(.WIDTH(32)) bus();
  divider #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    string       nm;
    logic        s;
    logic [31:0] a, b, q, r;
    logic        dz, ov;
    int          lat;
  } vec_t;
  int total = 0;
  int bad = 0;
  vec_t v[11];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    bus.isSigned = s;
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  task automatic wait_done(input bit spam, output int lat, output int bcnt, output int dcnt);
    lat = -1;
    bcnt = 0;
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!bus.busy) break;
      bcnt++;
      if (bus.done) begin
        dcnt++;
        if (lat < 0) lat = k;
      end
      if (spam) begin
        bus.start    = 1'b1;
        bus.isSigned = 1'b0;
        bus.dividend = 32'd9;
        bus.divisor  = 32'd3;
      end
    end
    bus.start = 1'b0;
  endtask
  task automatic run(input vec_t t, input bit spam);
    int lat, bc, dc;
    issue(t.s, t.a, t.b);
    wait_done(spam, lat, bc, dc);
    check({t.nm, " latency"}, 32'(lat), 32'(t.lat));
    check({t.nm, " busy cycles"}, 32'(bc), 32'(t.lat + 1));
    check({t.nm, " done pulses"}, 32'(dc), 32'd1);
    check({t.nm, " quotient"}, bus.quotient, t.q);
    check({t.nm, " remainder"}, bus.remainder, t.r);
    check({t.nm, " divByZero"}, 32'(bus.divByZero), 32'(t.dz));
    check({t.nm, " overflow"}, 32'(bus.overflow), 32'(t.ov));
  endtask
  task automatic check_zero(input string nm);
    check({nm, " busy"}, 32'(bus.busy), 32'd0);
    check({nm, " done"}, 32'(bus.done), 32'd0);
    check({nm, " quotient"}, bus.quotient, 32'd0);
    check({nm, " remainder"}, bus.remainder, 32'd0);
    check({nm, " divByZero"}, 32'(bus.divByZero), 32'd0);
    check({nm, " overflow"}, 32'(bus.overflow), 32'd0);
  endtask
  initial begin
    v[0]  = '{"u100/7",      1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 32};
    v[1]  = '{"s-7/2",       1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 32};
    v[2]  = '{"u-7bits/2",   1'b0, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 32'h00000001, 1'b0, 1'b0, 32};
    v[3]  = '{"s5/0",        1'b1, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 1'b0, 1};
    v[4]  = '{"u5/0",        1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 1'b0, 1};
    v[5]  = '{"sMIN/-1",     1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 1'b1, 1};
    v[6]  = '{"uMIN/max",    1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 1'b0, 32};
    v[7]  = '{"s7/-2",       1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 1'b0, 32};
    v[8]  = '{"s-100/-7",    1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 1'b0, 32};
    v[9]  = '{"umax/3",      1'b0, 32'hFFFFFFFF, 32'd3,        32'h55555555, 32'd0,        1'b0, 1'b0, 32};
    v[10] = '{"u0/5",        1'b0, 32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 1'b0, 32};
    bus.start = 1'b0;
    bus.isSigned = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 11; i++) run(v[i], 1'b0);
    run(v[0], 1'b1);
    run('{"u9/3 after busy", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 32}, 1'b0);
    issue(1'b0, 32'hFFFFFFFF, 32'd3);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1 check_zero("midrun reset");
    repeat (3) @(negedge clk);
    check({"reset hold done"}, 32'(bus.done), 32'd0);
    check({"reset hold busy"}, 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check({"post reset done"}, 32'(bus.done), 32'd0);
    run(v[9], 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/divider.md
# divider

Iterative radix-2 restoring integer divider for the Abejaruco execution stage. It computes quotient and remainder of two WIDTH-bit operands, in either signed or unsigned mode. It sits beside the pipelined multiplier and is driven by the same issue logic through a start/busy/done handshake. Results and corner cases follow RISC-V M-extension semantics: division by zero and signed overflow are handled without traps.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 2
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous and active-low
- start  input  1  request; sampled only in IDLE
- isSigned  input  1  1 = two's-complement operands, 0 = unsigned
- dividend  input  WIDTH  numerator, sampled with accepted start
- divisor  input  WIDTH  denominator, sampled with accepted start
- busy  output  1  high in RUN and DONE states
- done  output  1  one-cycle pulse; results valid this cycle
- quotient  output  WIDTH  result quotient
- remainder  output  WIDTH  result remainder; sign follows dividend
- divByZero  output  1  set with done when divisor == 0
- overflow  output  1  set with done for signed MIN / -1

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1: latch operands, isSigned, and sign flags (negQ = sign(dividend) XOR sign(divisor), negR = sign(dividend)); clear done/divByZero/overflow.
  - divisor==0: go to DONE with quotient=all ones, remainder=dividend, divByZero=1.
  - isSigned and dividend=MIN (only MSB set) and divisor=all ones: go to DONE with quotient=MIN, remainder=0, overflow=1.
  - Otherwise: load magnitudes (absolute values when isSigned, raw bits otherwise); clear the WIDTH+1-bit partial remainder; count=0; go to RUN.
- IDLE, start=0: hold all outputs.
- RUN, each cycle:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - trial = partial remainder − divisor magnitude.
  - If trial ≥ 0: partial remainder = trial and the quotient bit is 1; else the remainder is restored and the quotient bit is 0.
  - count increments.
- RUN, on the cycle performing iteration WIDTH−1: apply sign fixup (negate quotient if negQ, negate remainder if negR, signed mode only), register quotient/remainder, go to DONE.
- DONE: done=1, busy=1 for exactly one cycle, then go to IDLE.
- start while busy (RUN or DONE) is ignored; no queuing.
- quotient, remainder, divByZero and overflow hold their values until the next accepted start. done is the only pulse.
- Arithmetic: the partial remainder is WIDTH+1 bits so the trial-subtract borrow is visible. Magnitude of MIN is 2^(WIDTH−1), representable unsigned. Unsigned mode never sets overflow.

## Timing
- Reset (rst_n=0, any time, including mid-RUN): state=IDLE, count=0, busy=0, done=0, quotient=0, remainder=0, divByZero=0, overflow=0. The in-flight operation is discarded with no done.
- Normal latency: start accepted at edge E0; RUN iterations occupy edges E1..E(WIDTH); done=1 in the cycle following edge E(WIDTH).
- Fast path (divide-by-zero, signed overflow): done=1 in the cycle following edge E1.
- busy rises after E0 and falls after the edge leaving DONE.
- Back-to-back throughput:
  - Normal: a new start is accepted in the first IDLE cycle, giving one operation per WIDTH+2 cycles.
  - Fast path: one operation per 3 cycles.
- No combinational path from inputs to outputs.

## Test plan
- Unsigned 100 / 7, start for 1 cycle → done exactly 32 cycles after the accept edge; quotient=14, remainder=2, flags 0; busy high 33 cycles.
- Signed −7 / 2 (0xFFFFFFF9 / 0x00000002) → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Unsigned mode on the same bits → quotient=0x7FFFFFFC, remainder=1.
- 5 / 0, both modes → done one cycle after accept; quotient=0xFFFFFFFF, remainder=5, divByZero=1, overflow=0.
- Signed 0x80000000 / 0xFFFFFFFF → done one cycle after accept; quotient=0x80000000, remainder=0, overflow=1. Unsigned mode on the same bits → quotient=0, remainder=0x80000000, overflow=0, full latency.
- Pulse start with 9 / 3 every cycle during an in-flight 100 / 7 → only 100 / 7 is reported (14 r 2); the next start after IDLE yields 3 r 0.
- Assert rst_n=0 at iteration 10 of 0xFFFFFFFF / 3 → all outputs 0 immediately, no done. After release, 0xFFFFFFFF / 3 → 0x55555555 r 0.
